// File: rtl/decode_stage_hz_if.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_hz_if
//  Description : Signal bundle between fetch / execute / writeback and the
//                RV32I decode stage.
//                slave  modport : decode stage side (inputs *_i, outputs *_o)
//                master modport : environment side (drives *_i, reads *_o)
//                Fetch side    : instr_valid_i, InstrD_i, instr_ready_o
//                Execute side  : flush_i, out_ready_i, out_valid_o and the
//                                registered D/E fields (*E_o)
//                Writeback     : RegWriteW_i, RdW_i, ResultW_i
//                Debug         : a0 (combinational view of x10)
//  Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_hz_if #(
    parameter int XLEN = 32
);
    logic            instr_valid_i;
    logic [31:0]     InstrD_i;
    logic            instr_ready_o;
    logic            flush_i;
    logic            out_ready_i;
    logic            RegWriteW_i;
    logic [4:0]      RdW_i;
    logic [XLEN-1:0] ResultW_i;
    logic            out_valid_o;
    logic [XLEN-1:0] RD1E_o;
    logic [XLEN-1:0] RD2E_o;
    logic [4:0]      Rs1E_o;
    logic [4:0]      Rs2E_o;
    logic [4:0]      RdE_o;
    logic [XLEN-1:0] ImmExtE_o;
    logic [3:0]      opclassE_o;
    logic [2:0]      funct3E_o;
    logic            funct7bE_o;
    logic            RegWriteE_o;
    logic            illegalE_o;
    logic [XLEN-1:0] a0;

    modport slave (
        input  instr_valid_i, InstrD_i, flush_i, out_ready_i,
               RegWriteW_i, RdW_i, ResultW_i,
        output instr_ready_o, out_valid_o, RD1E_o, RD2E_o, Rs1E_o, Rs2E_o,
               RdE_o, ImmExtE_o, opclassE_o, funct3E_o, funct7bE_o,
               RegWriteE_o, illegalE_o, a0
    );

    modport master (
        output instr_valid_i, InstrD_i, flush_i, out_ready_i,
               RegWriteW_i, RdW_i, ResultW_i,
        input  instr_ready_o, out_valid_o, RD1E_o, RD2E_o, Rs1E_o, Rs2E_o,
               RdE_o, ImmExtE_o, opclassE_o, funct3E_o, funct7bE_o,
               RegWriteE_o, illegalE_o, a0
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage_hz.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage_hz
//  Description : RV32I/RV32E decode stage: field extraction, register file
//                with optional WB write-through, immediate generation and the
//                D/E pipeline register, with valid/ready flow control,
//                load-use bubble insertion and branch flush.
//  Ports       : clk   - clock
//                rst_n - synchronous active-low reset
//                bus   - decode_stage_hz_if.slave (fetch/execute/WB bundle)
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage_hz #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    decode_stage_hz_if.slave  bus
);
    localparam int         RW     = $clog2(NREG);
    localparam logic [5:0] c_nreg = 6'(NREG);

    localparam logic [3:0] c_cls_op    = 4'd0;
    localparam logic [3:0] c_cls_opimm = 4'd1;
    localparam logic [3:0] c_cls_load  = 4'd2;
    localparam logic [3:0] c_cls_store = 4'd3;
    localparam logic [3:0] c_cls_br    = 4'd4;
    localparam logic [3:0] c_cls_jal   = 4'd5;
    localparam logic [3:0] c_cls_jalr  = 4'd6;
    localparam logic [3:0] c_cls_lui   = 4'd7;
    localparam logic [3:0] c_cls_auipc = 4'd8;
    localparam logic [3:0] c_cls_ill   = 4'd15;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_regs [NREG];
    logic            w_wb_en;

    // x0 is never written, so it stays at its reset value of zero.
    assign w_wb_en = bus.RegWriteW_i && (bus.RdW_i != 5'd0) && ({1'b0, bus.RdW_i} < c_nreg);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (w_wb_en) begin
            r_regs[bus.RdW_i[RW-1:0]] <= bus.ResultW_i;
        end
    end

    logic [31:0]     w_instr;
    logic [4:0]      w_rs   [2];
    logic [XLEN-1:0] w_rdat [2];
    logic [4:0]      w_rd;

    assign w_instr = bus.InstrD_i;
    assign w_rs[0] = w_instr[19:15];
    assign w_rs[1] = w_instr[24:20];
    assign w_rd    = w_instr[11:7];

    // Out-of-range indices read zero; such instructions are flagged illegal.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdat[p] = '0;
            if (w_rs[p] != 5'd0 && {1'b0, w_rs[p]} < c_nreg) begin
                if (BYPASS != 0 && w_wb_en && bus.RdW_i == w_rs[p])
                    w_rdat[p] = bus.ResultW_i;
                else
                    w_rdat[p] = r_regs[w_rs[p][RW-1:0]];
            end
        end
    end

    if (NREG > 10) begin : g_a0_reg
        assign bus.a0 = r_regs[10];
    end else begin : g_a0_none
        assign bus.a0 = '0;
    end

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic [3:0]        w_cls_raw;
    logic              w_use_rs1, w_use_rs2, w_use_rd;
    logic signed [31:0] w_imm32;
    logic              w_idx_bad, w_illegal, w_regwrite;
    logic [3:0]        w_cls;
    logic [XLEN-1:0]   w_imm;

    always_comb begin
        w_cls_raw = c_cls_ill;
        w_use_rs1 = 1'b0;
        w_use_rs2 = 1'b0;
        w_use_rd  = 1'b0;
        w_imm32   = '0;
        case (w_instr[6:0])
            7'b0110011: begin w_cls_raw = c_cls_op;    w_use_rs1 = 1'b1; w_use_rs2 = 1'b1; w_use_rd = 1'b1; end
            7'b0010011: begin w_cls_raw = c_cls_opimm; w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                              w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]}; end
            7'b0000011: begin w_cls_raw = c_cls_load;  w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                              w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]}; end
            7'b0100011: begin w_cls_raw = c_cls_store; w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                              w_imm32 = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]}; end
            7'b1100011: begin w_cls_raw = c_cls_br;    w_use_rs1 = 1'b1; w_use_rs2 = 1'b1;
                              w_imm32 = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0}; end
            7'b1101111: begin w_cls_raw = c_cls_jal;   w_use_rd = 1'b1;
                              w_imm32 = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0}; end
            7'b1100111: begin w_cls_raw = c_cls_jalr;  w_use_rs1 = 1'b1; w_use_rd = 1'b1;
                              w_imm32 = {{20{w_instr[31]}}, w_instr[31:20]}; end
            7'b0110111: begin w_cls_raw = c_cls_lui;   w_use_rd = 1'b1;
                              w_imm32 = {w_instr[31:12], 12'b0}; end
            7'b0010111: begin w_cls_raw = c_cls_auipc; w_use_rd = 1'b1;
                              w_imm32 = {w_instr[31:12], 12'b0}; end
            default: ;
        endcase
    end

    assign w_idx_bad  = (w_use_rs1 && {1'b0, w_rs[0]} >= c_nreg) ||
                        (w_use_rs2 && {1'b0, w_rs[1]} >= c_nreg) ||
                        (w_use_rd  && {1'b0, w_rd}    >= c_nreg);
    assign w_illegal  = (w_cls_raw == c_cls_ill) || w_idx_bad;
    assign w_cls      = w_illegal ? c_cls_ill : w_cls_raw;
    assign w_imm      = w_illegal ? '0 : XLEN'(w_imm32);
    assign w_regwrite = w_use_rd && (w_rd != 5'd0) && !w_illegal;

    // ------------------------------------------------------------------
    // Flow control and load-use hazard
    // ------------------------------------------------------------------
    logic            r_valid, r_rw, r_ill, r_f7b;
    logic [XLEN-1:0] r_rd1, r_rd2, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd;
    logic [3:0]      r_cls;
    logic [2:0]      r_f3;
    logic            w_advance, w_hz;

    // Use flags come from the opcode alone so a bad-index instruction still
    // waits behind a load rather than slipping past it.
    assign w_hz = bus.instr_valid_i && r_valid && (r_cls == c_cls_load) && (r_rd != 5'd0) &&
                  ((w_use_rs1 && w_rs[0] == r_rd) || (w_use_rs2 && w_rs[1] == r_rd));
    assign w_advance         = !r_valid || bus.out_ready_i;
    assign bus.instr_ready_o = rst_n && w_advance && !w_hz && !bus.flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0; r_rw  <= 1'b0; r_ill <= 1'b0; r_f7b <= 1'b0;
            r_rd1   <= '0;   r_rd2 <= '0;   r_imm <= '0;
            r_rs1   <= '0;   r_rs2 <= '0;   r_rd  <= '0;
            r_cls   <= '0;   r_f3  <= '0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
            r_rw    <= 1'b0;
        end else if (!w_advance) begin
            // Execute is stalled: hold the slot as is.
        end else if (w_hz) begin
            r_valid <= 1'b0;
            r_rw    <= 1'b0;
        end else begin
            r_valid <= bus.instr_valid_i;
            r_rw    <= bus.instr_valid_i && w_regwrite;
            r_ill   <= w_illegal;
            r_f7b   <= w_instr[30];
            r_rd1   <= w_rdat[0];
            r_rd2   <= w_rdat[1];
            r_imm   <= w_imm;
            r_rs1   <= w_rs[0];
            r_rs2   <= w_rs[1];
            r_rd    <= w_rd;
            r_cls   <= w_cls;
            r_f3    <= w_instr[14:12];
        end
    end

    assign bus.out_valid_o = r_valid;
    assign bus.RD1E_o      = r_rd1;
    assign bus.RD2E_o      = r_rd2;
    assign bus.Rs1E_o      = r_rs1;
    assign bus.Rs2E_o      = r_rs2;
    assign bus.RdE_o       = r_rd;
    assign bus.ImmExtE_o   = r_imm;
    assign bus.opclassE_o  = r_cls;
    assign bus.funct3E_o   = r_f3;
    assign bus.funct7bE_o  = r_f7b;
    assign bus.RegWriteE_o = r_rw;
    assign bus.illegalE_o  = r_ill;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage_hz.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_stage_hz
//  Description : Self-checking bench for decode_stage_hz. Three instances
//                share one stimulus: A (BYPASS=1, NREG=32), B (BYPASS=0),
//                C (NREG=16). Directed decode vectors from a table, then
//                hand-written bypass, load-use, stall, flush and reset cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage_hz;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, instr_valid, flush, out_ready, wb_en;
    logic [31:0] instr, wb_data;
    logic [4:0]  wb_rd;

    decode_stage_hz_if #(.XLEN(32)) bus_a ();
    decode_stage_hz_if #(.XLEN(32)) bus_b ();
    decode_stage_hz_if #(.XLEN(32)) bus_c ();

    assign bus_a.instr_valid_i = instr_valid; assign bus_a.InstrD_i = instr;
    assign bus_a.flush_i = flush;             assign bus_a.out_ready_i = out_ready;
    assign bus_a.RegWriteW_i = wb_en;         assign bus_a.RdW_i = wb_rd;
    assign bus_a.ResultW_i = wb_data;
    assign bus_b.instr_valid_i = instr_valid; assign bus_b.InstrD_i = instr;
    assign bus_b.flush_i = flush;             assign bus_b.out_ready_i = out_ready;
    assign bus_b.RegWriteW_i = wb_en;         assign bus_b.RdW_i = wb_rd;
    assign bus_b.ResultW_i = wb_data;
    assign bus_c.instr_valid_i = instr_valid; assign bus_c.InstrD_i = instr;
    assign bus_c.flush_i = flush;             assign bus_c.out_ready_i = out_ready;
    assign bus_c.RegWriteW_i = wb_en;         assign bus_c.RdW_i = wb_rd;
    assign bus_c.ResultW_i = wb_data;

    decode_stage_hz #(.XLEN(32), .NREG(32), .BYPASS(1)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    decode_stage_hz #(.XLEN(32), .NREG(32), .BYPASS(0)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    decode_stage_hz #(.XLEN(32), .NREG(16), .BYPASS(1)) u_dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [31:0] instr;
        logic        valid;
        logic        exp_valid;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [3:0]  cls;
        logic        rw;
        logic        ill;
        logic        ill16;
    } vec_t;

    localparam int NV = 12;
    vec_t vecs [NV];

    initial begin
        //                instr         v     ev    imm           rd     rs1    cls    rw    ill   ill16
        vecs[0]  = '{32'h00500093, 1'b1, 1'b1, 32'h00000005, 5'd1,  5'd0,  4'd1,  1'b1, 1'b0, 1'b0}; // addi x1,x0,5
        vecs[1]  = '{32'hFE000EE3, 1'b1, 1'b1, 32'hFFFFFFFC, 5'd29, 5'd0,  4'd4,  1'b0, 1'b0, 1'b0}; // beq -4
        vecs[2]  = '{32'h0080006F, 1'b1, 1'b1, 32'h00000008, 5'd0,  5'd0,  4'd5,  1'b0, 1'b0, 1'b0}; // jal x0,8
        vecs[3]  = '{32'h123453B7, 1'b1, 1'b1, 32'h12345000, 5'd7,  5'd8,  4'd7,  1'b1, 1'b0, 1'b0}; // lui x7
        vecs[4]  = '{32'hFE20AE23, 1'b1, 1'b1, 32'hFFFFFFFC, 5'd28, 5'd1,  4'd3,  1'b0, 1'b0, 1'b0}; // sw x2,-4(x1)
        vecs[5]  = '{32'h002101B3, 1'b1, 1'b1, 32'h00000000, 5'd3,  5'd2,  4'd0,  1'b1, 1'b0, 1'b0}; // add x3,x2,x2
        vecs[6]  = '{32'h80000217, 1'b1, 1'b1, 32'h80000000, 5'd4,  5'd0,  4'd8,  1'b1, 1'b0, 1'b0}; // auipc x4
        vecs[7]  = '{32'h010280E7, 1'b1, 1'b1, 32'h00000010, 5'd1,  5'd5,  4'd6,  1'b1, 1'b0, 1'b0}; // jalr x1,16(x5)
        vecs[8]  = '{32'h00100A13, 1'b1, 1'b1, 32'h00000001, 5'd20, 5'd0,  4'd1,  1'b1, 1'b0, 1'b1}; // addi x20,x0,1
        vecs[9]  = '{32'hFF812283, 1'b1, 1'b1, 32'hFFFFFFF8, 5'd5,  5'd2,  4'd2,  1'b1, 1'b0, 1'b0}; // lw x5,-8(x2)
        vecs[10] = '{32'hFFFFFFFF, 1'b1, 1'b1, 32'h00000000, 5'd31, 5'd31, 4'd15, 1'b0, 1'b1, 1'b1}; // bad opcode
        vecs[11] = '{32'h00500093, 1'b0, 1'b0, 32'h00000000, 5'd0,  5'd0,  4'd0,  1'b0, 1'b0, 1'b0}; // not valid

        rst_n = 1'b0; instr_valid = 1'b1; instr = 32'h00500093; flush = 1'b0;
        out_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset
        step(); step(); step();
        chk("rst_ready",  {31'b0, bus_a.instr_ready_o}, 32'd0);
        chk("rst_valid",  {31'b0, bus_a.out_valid_o}, 32'd0);
        chk("rst_rw",     {31'b0, bus_a.RegWriteE_o}, 32'd0);
        chk("rst_imm",    bus_a.ImmExtE_o, 32'd0);
        chk("rst_rd",     {27'b0, bus_a.RdE_o}, 32'd0);
        chk("rst_a0",     bus_a.a0, 32'd0);
        rst_n = 1'b1;

        // Decode table
        for (int i = 0; i < NV; i++) begin
            instr = vecs[i].instr;
            instr_valid = vecs[i].valid;
            #1;
            chk($sformatf("v%0d_ready", i), {31'b0, bus_a.instr_ready_o}, 32'd1);
            step();
            chk($sformatf("v%0d_valid", i), {31'b0, bus_a.out_valid_o}, {31'b0, vecs[i].exp_valid});
            chk($sformatf("v%0d_rw", i),    {31'b0, bus_a.RegWriteE_o}, {31'b0, vecs[i].rw});
            if (vecs[i].exp_valid) begin
                chk($sformatf("v%0d_imm", i), bus_a.ImmExtE_o, vecs[i].imm);
                chk($sformatf("v%0d_rd", i),  {27'b0, bus_a.RdE_o}, {27'b0, vecs[i].rd});
                chk($sformatf("v%0d_rs1", i), {27'b0, bus_a.Rs1E_o}, {27'b0, vecs[i].rs1});
                chk($sformatf("v%0d_cls", i), {28'b0, bus_a.opclassE_o}, {28'b0, vecs[i].cls});
                chk($sformatf("v%0d_ill", i), {31'b0, bus_a.illegalE_o}, {31'b0, vecs[i].ill});
                chk($sformatf("v%0d_ill16", i), {31'b0, bus_c.illegalE_o}, {31'b0, vecs[i].ill16});
                chk($sformatf("v%0d_rw16", i), {31'b0, bus_c.RegWriteE_o},
                    {31'b0, vecs[i].rw & ~vecs[i].ill16});
            end
        end

        // WB write-through: add x3,x2,x2 while x2 is written
        instr = 32'h002101B3; instr_valid = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hDEADBEEF;
        step();
        chk("byp_rd1_a", bus_a.RD1E_o, 32'hDEADBEEF);
        chk("byp_rd2_a", bus_a.RD2E_o, 32'hDEADBEEF);
        chk("byp_rd1_b", bus_b.RD1E_o, 32'h0);
        chk("byp_rd2_b", bus_b.RD2E_o, 32'h0);
        wb_en = 1'b0;
        step();
        chk("nobyp_rd1_b", bus_b.RD1E_o, 32'hDEADBEEF);

        // x0 write ignored: add x3,x0,x0 while WB targets x0
        instr = 32'h000001B3; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
        step();
        chk("x0_byp", bus_a.RD1E_o, 32'h0);
        wb_en = 1'b0;
        step();
        chk("x0_reg", bus_a.RD1E_o, 32'h0);

        // Load-use: lw x5,0(x1) then add x6,x5,x0
        instr = 32'h0000A283;
        step();
        chk("lu_load_cls", {28'b0, bus_a.opclassE_o}, 32'd2);
        instr = 32'h00028333;
        #1;
        chk("lu_ready0", {31'b0, bus_a.instr_ready_o}, 32'd0);
        step();
        chk("lu_bubble", {31'b0, bus_a.out_valid_o}, 32'd0);
        chk("lu_bub_rw", {31'b0, bus_a.RegWriteE_o}, 32'd0);
        chk("lu_ready1", {31'b0, bus_a.instr_ready_o}, 32'd1);
        step();
        chk("lu_issue",  {31'b0, bus_a.out_valid_o}, 32'd1);
        chk("lu_rs1",    {27'b0, bus_a.Rs1E_o}, 32'd5);
        chk("lu_rd",     {27'b0, bus_a.RdE_o}, 32'd6);

        // Stall: execute not ready for 3 cycles
        out_ready = 1'b0; instr = 32'h00500093;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("st%0d_ready", c), {31'b0, bus_a.instr_ready_o}, 32'd0);
            step();
            chk($sformatf("st%0d_valid", c), {31'b0, bus_a.out_valid_o}, 32'd1);
            chk($sformatf("st%0d_rd", c),    {27'b0, bus_a.RdE_o}, 32'd6);
        end
        out_ready = 1'b1;
        #1;
        chk("st_release", {31'b0, bus_a.instr_ready_o}, 32'd1);
        step();
        chk("st_adv_rd",  {27'b0, bus_a.RdE_o}, 32'd1);
        chk("st_adv_imm", bus_a.ImmExtE_o, 32'd5);

        // Flush with a simultaneous WB write of x9
        instr = 32'h123453B7; flush = 1'b1;
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 32'h00000055;
        #1;
        chk("fl_ready", {31'b0, bus_a.instr_ready_o}, 32'd0);
        step();
        chk("fl_valid", {31'b0, bus_a.out_valid_o}, 32'd0);
        chk("fl_rw",    {31'b0, bus_a.RegWriteE_o}, 32'd0);
        flush = 1'b0; wb_en = 1'b0;
        instr = 32'h000481B3;   // add x3,x9,x0
        step();
        chk("fl_wb_a", bus_a.RD1E_o, 32'h55);
        chk("fl_wb_b", bus_b.RD1E_o, 32'h55);

        // a0 view, then reset in the middle of a stall
        instr_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'h1234ABCD;
        step();
        chk("a0_val", bus_a.a0, 32'h1234ABCD);
        wb_en = 1'b0; instr_valid = 1'b1; instr = 32'h00500093;
        step();
        chk("mr_slot", {31'b0, bus_a.out_valid_o}, 32'd1);
        out_ready = 1'b0; rst_n = 1'b0;
        #1;
        chk("mr_ready", {31'b0, bus_a.instr_ready_o}, 32'd0);
        step();
        chk("mr_valid", {31'b0, bus_a.out_valid_o}, 32'd0);
        chk("mr_a0",    bus_a.a0, 32'd0);
        rst_n = 1'b1; out_ready = 1'b1; instr_valid = 1'b0;
        step();
        chk("mr_idle",  {31'b0, bus_a.out_valid_o}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
